// File: rtl/switch_debounce3_pkg.sv
// Shared constants for the switch input-conditioning stage and the wiring
// into the downstream a/b/c combinational circuit.
package switch_debounce3_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Bit positions of the downstream circuit inputs within clean_out.
    localparam int CH_A = 2;
    localparam int CH_B = 1;
    localparam int CH_C = 0;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, stability counter, clean level
// flop and registered one-cycle rise/fall pulses.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Count only while the synchronized level disagrees with the
            // clean level; any agreement throws the partial count away.
            if (sync2 == clean) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                clean <= sync2;
                count <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce3.sv
// Synchronizes and debounces the board switches feeding the a/b/c circuit;
// one debounce_channel per bit plus a combined change flag.
module switch_debounce3
    import switch_debounce3_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_in[i]),
            .clean(clean_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end

    // Pulses are already registered, so this OR adds no path from raw_in.
    assign changed = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_switch_debounce3.sv
// Bench for switch_debounce3 at DEBOUNCE_CYCLES=4: a history-based reference
// model feeds an expected queue; each scenario also checks fixed timings.
module tb_switch_debounce3;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int VW = 3 * W + 1;

    logic          clk;
    logic          rst;
    logic [W-1:0]  raw_in;
    logic [W-1:0]  clean_out;
    logic [W-1:0]  rise_pulse;
    logic [W-1:0]  fall_pulse;
    logic          changed;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] obs_v;
    logic [VW-1:0] exp_v;
    logic [VW-1:0] exp_c;

    switch_debounce3 #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .changed   (changed)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // clean flips once the last D synchronized samples all differ from it.
    logic [W-1:0] m_s1, m_s2, m_clean;
    logic [D-1:0] hist [W];

    always @(posedge clk) begin
        logic [W-1:0] nclean, rise_m, fall_m;
        logic [D-1:0] h;
        if (rst) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_clean <= '0;
            for (int i = 0; i < W; i++) hist[i] <= '0;
            exp_q.push_back('0);
        end else begin
            nclean = m_clean;
            for (int i = 0; i < W; i++) begin
                h = {hist[i][D-2:0], m_s2[i]};
                if (h == {D{~m_clean[i]}}) nclean[i] = ~m_clean[i];
                hist[i] <= h;
            end
            rise_m = nclean & ~m_clean;
            fall_m = ~nclean & m_clean;
            m_s1    <= raw_in;
            m_s2    <= m_s1;
            m_clean <= nclean;
            exp_q.push_back({nclean, rise_m, fall_m, |(rise_m | fall_m)});
        end
    end

    // ---------------- driver ----------------
    task automatic next_cycle();
        @(negedge clk);
        obs_v = {clean_out, rise_pulse, fall_pulse, changed};
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        else exp_v = 'x;
    endtask

    task automatic settle(input logic [W-1:0] v);
        raw_in = v;
        for (int k = 0; k < 2 * D; k++) begin
            next_cycle();
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL settle_model: observed %b expected %b", obs_v, exp_v);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        raw_in = 3'b111;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            tests_run++;
            if (obs_v !== {VW{1'b0}} || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_hold: observed %b expected %b", obs_v, {VW{1'b0}});
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k < 5)       exp_c = '0;
            else if (k == 5) exp_c = {3'b111, 3'b111, 3'b000, 1'b1};
            else             exp_c = {3'b111, 3'b000, 3'b000, 1'b0};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_release k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
    endtask

    task automatic test_clean_step();
        settle(3'b000);
        raw_in = 3'b001;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            exp_c = {2'b00, (k >= 5), 2'b00, (k == 5), 3'b000, (k == 5)};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL clean_step k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
    endtask

    task automatic test_bounce_reject();
        for (int k = 0; k < 10; k++) begin
            raw_in = (k < 3) ? 3'b011 : 3'b001;
            next_cycle();
            exp_c = {3'b001, 3'b000, 3'b000, 1'b0};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL bounce_reject k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
    endtask

    task automatic test_bounce_settle();
        logic [4:0] pat;
        int rises;
        pat = 5'b10101;
        rises = 0;
        for (int k = 0; k < 13; k++) begin
            raw_in = {((k < 5) ? pat[k] : 1'b1), 2'b01};
            next_cycle();
            if (rise_pulse[2]) rises++;
            exp_c = {(k >= 9), 2'b01, (k == 9), 2'b00, 3'b000, (k == 9)};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL bounce_settle k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
        tests_run++;
        if (rises !== 1) begin
            tests_failed++;
            $display("FAIL bounce_settle_count: observed %0d rises expected 1", rises);
        end
    endtask

    task automatic test_simultaneous();
        raw_in = 3'b010;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k < 5)       exp_c = {3'b101, 3'b000, 3'b000, 1'b0};
            else if (k == 5) exp_c = {3'b010, 3'b010, 3'b101, 1'b1};
            else             exp_c = {3'b010, 3'b000, 3'b000, 1'b0};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL simultaneous k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(3'b000);
        raw_in = 3'b001;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            tests_run++;
            if (obs_v !== {VW{1'b0}} || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_pre k=%0d: observed %b expected %b", k, obs_v, {VW{1'b0}});
            end
        end
        rst = 1'b1;
        next_cycle();
        tests_run++;
        if (obs_v !== {VW{1'b0}} || obs_v !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: observed %b expected %b", obs_v, {VW{1'b0}});
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            exp_c = {2'b00, (k >= 5), 2'b00, (k == 5), 3'b000, (k == 5)};
            tests_run++;
            if (obs_v !== exp_c || obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_restart k=%0d: observed %b expected %b", k, obs_v, exp_c);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hold;
        for (int s = 0; s < 60; s++) begin
            raw_in = W'($urandom_range(0, 7));
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                next_cycle();
                tests_run++;
                if (obs_v !== exp_v || (rise_pulse & fall_pulse) !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL random s=%0d: observed %b expected %b", s, obs_v, exp_v);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        raw_in = 3'b111;
        test_reset();
        test_clean_step();
        test_bounce_reject();
        test_bounce_settle();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
